// File: rtl/ibex_dummy_instr_gen.sv
// Dummy instruction generator: an LFSR-derived threshold paces bursts of random
// register-register ALU instructions that the ID stage may accept.
module ibex_dummy_instr_gen #(
  parameter int unsigned  CntW     = 5,
  parameter int unsigned  MaskW    = 3,
  parameter int unsigned  MaxBurst = 4,
  parameter logic [31:0]  LfsrSeed = 32'h0000_0003,
  parameter logic [31:0]  LfsrPoly = 32'h8020_0003,
  localparam int unsigned BurstW   = $clog2(MaxBurst) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dummy_instr_en_i,
  input  logic [MaskW-1:0]  dummy_instr_mask_i,
  input  logic [3:0]        dummy_type_en_i,
  input  logic [BurstW-1:0] dummy_burst_len_i,
  input  logic              dummy_instr_seed_en_i,
  input  logic [31:0]       dummy_instr_seed_i,
  input  logic              fetch_valid_i,
  input  logic              id_in_ready_i,
  output logic              insert_dummy_instr_o,
  output logic [31:0]       dummy_instr_data_o,
  output logic [15:0]       dummy_count_o
);

  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [BurstW-1:0] MaxBurstV = BurstW'(MaxBurst);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [BurstW-1:0] burst_rem_q;
  logic [31:0]       lfsr_q, lfsr_d, lfsr_adv, lfsr_seeded;
  logic [15:0]       count_q;
  logic [CntW-1:0]   thr_mask, threshold;
  logic [BurstW-1:0] burst_load;
  logic [1:0]        lfsr_type, type_sel, type_idx;
  logic              type_found;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic              insert, accept;

  // Low threshold bits are always enabled; the mask only trims the upper ones.
  generate
    if (MaskW == CntW) begin : g_full_mask
      assign thr_mask = dummy_instr_mask_i;
    end else begin : g_part_mask
      assign thr_mask = {dummy_instr_mask_i, {(CntW - MaskW){1'b1}}};
    end
  endgenerate

  assign threshold = lfsr_q[CntW-1:0] & thr_mask;
  assign insert    = (state_q == BURST) & dummy_instr_en_i & ~rst_i;
  assign accept    = insert & id_in_ready_i;

  always_comb begin
    lfsr_adv    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrPoly : 32'h0);
    lfsr_seeded = lfsr_q ^ dummy_instr_seed_i;
    if (lfsr_seeded == 32'h0) lfsr_seeded = LfsrSeed;
    lfsr_d = lfsr_q;
    if (dummy_instr_seed_en_i) lfsr_d = lfsr_seeded;
    else if (accept)           lfsr_d = lfsr_adv;
  end

  always_comb begin
    if (dummy_burst_len_i == '0)           burst_load = BurstW'(1);
    else if (dummy_burst_len_i > MaxBurstV) burst_load = MaxBurstV;
    else                                    burst_load = dummy_burst_len_i;
  end

  // Rotate from the LFSR-chosen type to the first enabled one; ADD if none.
  always_comb begin
    lfsr_type  = lfsr_q[CntW+11:CntW+10];
    type_sel   = 2'd0;
    type_found = 1'b0;
    type_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      type_idx = lfsr_type + 2'(k);
      if (!type_found && dummy_type_en_i[type_idx]) begin
        type_sel   = type_idx;
        type_found = 1'b1;
      end
    end
    case (type_sel)
      2'd1:    begin funct7 = 7'b0000001; funct3 = 3'b000; end
      2'd2:    begin funct7 = 7'b0000001; funct3 = 3'b100; end
      2'd3:    begin funct7 = 7'b0000000; funct3 = 3'b111; end
      default: begin funct7 = 7'b0000000; funct3 = 3'b000; end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      burst_rem_q <= '0;
      lfsr_q      <= LfsrSeed;
      count_q     <= 16'h0;
    end else begin
      lfsr_q <= lfsr_d;
      if (accept && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (dummy_instr_en_i && cnt_q == threshold) begin
            state_q     <= BURST;
            cnt_q       <= '0;
            burst_rem_q <= burst_load;
          end else if (dummy_instr_en_i && id_in_ready_i && fetch_valid_i) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        BURST: begin
          if (accept) burst_rem_q <= burst_rem_q - BurstW'(1);
          if (!dummy_instr_en_i || (accept && burst_rem_q == BurstW'(1))) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign insert_dummy_instr_o = insert;
  assign dummy_instr_data_o   = insert ? {funct7, lfsr_q[CntW+9:CntW+5], lfsr_q[CntW+4:CntW],
                                          funct3, 5'h00, 7'h33} : 32'h0;
  assign dummy_count_o        = count_q;

endmodule

// File: tb/tb_ibex_dummy_instr_gen.sv
// Self-checking bench for ibex_dummy_instr_gen: directed scenarios plus a random
// run, all compared against an arithmetic reference model of the generator.
module tb_ibex_dummy_instr_gen;

  localparam logic [31:0] SEED = 32'h0000_0003;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rstI, enI, seedEnI, fvI, rdyI;
  logic [2:0]  maskI, burstLenI;
  logic [3:0]  typeEnI;
  logic [31:0] seedI;
  logic        insertO;
  logic [31:0] dataO;
  logic [15:0] countO;

  int nCmp = 0;
  int nBad = 0;

  logic [31:0] mLfsr;
  bit          mBurst;
  int          mCnt, mRem, mCount;

  always #5 clk = ~clk;

  ibex_dummy_instr_gen dut (
    .clk_i                (clk),
    .rst_i                (rstI),
    .dummy_instr_en_i     (enI),
    .dummy_instr_mask_i   (maskI),
    .dummy_type_en_i      (typeEnI),
    .dummy_burst_len_i    (burstLenI),
    .dummy_instr_seed_en_i(seedEnI),
    .dummy_instr_seed_i   (seedI),
    .fetch_valid_i        (fvI),
    .id_in_ready_i        (rdyI),
    .insert_dummy_instr_o (insertO),
    .dummy_instr_data_o   (dataO),
    .dummy_count_o        (countO)
  );

  // Reference model: integers and lookup tables derived from the generator's rules.
  function automatic logic [31:0] refAdvance(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  function automatic int refThreshold(input logic [31:0] s, input logic [2:0] m);
    return int'(s & 32'h1f) & ((int'(m) << 2) | 3);
  endfunction

  function automatic logic [31:0] refEncoding(input logic [31:0] s, input logic [3:0] typeEn);
    int f7Tab[4] = '{0, 1, 1, 0};
    int f3Tab[4] = '{0, 0, 4, 7};
    int t = int'((s >> 15) % 4);
    int sel = 0;
    for (int k = 3; k >= 0; k--) if (typeEn[(t + k) % 4]) sel = (t + k) % 4;
    return (32'(f7Tab[sel]) << 25) | (((s >> 10) & 32'h1f) << 20) |
           (((s >> 5) & 32'h1f) << 15) | (32'(f3Tab[sel]) << 12) | 32'h33;
  endfunction

  task automatic modelStep();
    logic [31:0] nextL;
    bit acc;
    int bl;
    if (rstI) begin
      mBurst = 0; mCnt = 0; mRem = 0; mLfsr = SEED; mCount = 0;
      return;
    end
    acc   = mBurst && enI && rdyI;
    nextL = mLfsr;
    if (seedEnI) begin
      nextL = mLfsr ^ seedI;
      if (nextL == 32'h0) nextL = SEED;
    end else if (acc) nextL = refAdvance(mLfsr);
    if (acc && mCount < 65535) mCount++;
    if (!mBurst) begin
      if (enI && mCnt == refThreshold(mLfsr, maskI)) begin
        bl = int'(burstLenI);
        mBurst = 1; mCnt = 0; mRem = (bl == 0) ? 1 : ((bl > 4) ? 4 : bl);
      end else if (enI && rdyI && fvI) mCnt = (mCnt + 1) % 32;
    end else begin
      if (acc) mRem--;
      if (!enI || (acc && mRem == 0)) mBurst = 0;
    end
    mLfsr = nextL;
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [2:0] mask,
                               input logic [3:0] typeEn, input logic [2:0] bl,
                               input logic seedEn, input logic [31:0] seed,
                               input logic fv, input logic rdy);
    @(negedge clk);
    rstI = rst; enI = en; maskI = mask; typeEnI = typeEn; burstLenI = bl;
    seedEnI = seedEn; seedI = seed; fvI = fv; rdyI = rdy;
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 3'h7, 4'hF, 3'd1, 1'b0, 32'h0, 1'b1, 1'b1);
    @(posedge clk);
    modelStep();
  endtask

  task automatic test_reset();
    resetDut();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 3'($urandom), 4'($urandom), 3'($urandom), 1'b0, $urandom, 1'b1, 1'b1);
      #1;
      nCmp += 3;
      if (insertO !== 1'b0) begin nBad++; $display("[TB] FAIL reset.insert got %0b want 0", insertO); end
      if (dataO !== 32'h0) begin nBad++; $display("[TB] FAIL reset.data got %h want 00000000", dataO); end
      if (countO !== 16'h0) begin nBad++; $display("[TB] FAIL reset.count got %0d want 0", countO); end
      @(posedge clk);
      modelStep();
    end
  endtask

  task automatic test_default_threshold();
    logic expIns;
    logic [31:0] expData;
    resetDut();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, 1'b1, 3'h7, 4'hF, 3'd1, 1'b0, 32'h0, 1'b1, 1'b1);
      #1;
      expIns  = mBurst && enI && !rstI;
      expData = expIns ? refEncoding(mLfsr, typeEnI) : 32'h0;
      nCmp += 3;
      if (insertO !== expIns) begin nBad++; $display("[TB] FAIL dflt.insert cyc %0d got %0b want %0b", c, insertO, expIns); end
      if (dataO !== expData) begin nBad++; $display("[TB] FAIL dflt.data cyc %0d got %h want %h", c, dataO, expData); end
      if (countO !== mCount[15:0]) begin nBad++; $display("[TB] FAIL dflt.count cyc %0d got %0d want %0d", c, countO, mCount); end
      if (c == 4 || c == 8) begin
        nCmp += 2;
        if (insertO !== 1'b1) begin nBad++; $display("[TB] FAIL dflt.first_insert cyc %0d got %0b want 1", c, insertO); end
        if (dataO !== 32'h0000_0033) begin nBad++; $display("[TB] FAIL dflt.first_data cyc %0d got %h want 00000033", c, dataO); end
      end
      @(posedge clk);
      modelStep();
    end
  endtask

  task automatic test_burst3();
    logic expIns;
    logic [31:0] expData;
    resetDut();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b1, 3'h7, 4'hF, 3'd3, 1'b0, 32'h0, 1'b1, 1'b1);
      #1;
      expIns  = mBurst && enI && !rstI;
      expData = expIns ? refEncoding(mLfsr, typeEnI) : 32'h0;
      nCmp += 2;
      if (insertO !== expIns) begin nBad++; $display("[TB] FAIL burst3.insert cyc %0d got %0b want %0b", c, insertO, expIns); end
      if (dataO !== expData) begin nBad++; $display("[TB] FAIL burst3.data cyc %0d got %h want %h", c, dataO, expData); end
      if (c >= 4 && c <= 6) begin
        nCmp++;
        if (insertO !== 1'b1) begin nBad++; $display("[TB] FAIL burst3.run cyc %0d got %0b want 1", c, insertO); end
      end
      if (c == 7) begin
        nCmp += 2;
        if (countO !== 16'd3) begin nBad++; $display("[TB] FAIL burst3.count got %0d want 3", countO); end
        if (insertO !== 1'b0) begin nBad++; $display("[TB] FAIL burst3.idle got %0b want 0", insertO); end
      end
      @(posedge clk);
      modelStep();
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    logic expIns;
    resetDut();
    held = 32'h0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, 1'b1, 3'h7, 4'hF, 3'd2, 1'b0, 32'h0, 1'b1, !(c >= 5 && c <= 8));
      #1;
      expIns = mBurst && enI && !rstI;
      nCmp += 2;
      if (insertO !== expIns) begin nBad++; $display("[TB] FAIL stall.insert cyc %0d got %0b want %0b", c, insertO, expIns); end
      if (countO !== mCount[15:0]) begin nBad++; $display("[TB] FAIL stall.count cyc %0d got %0d want %0d", c, countO, mCount); end
      if (c == 5) held = refEncoding(mLfsr, typeEnI);
      if (c >= 5 && c <= 9) begin
        nCmp += 2;
        if (insertO !== 1'b1) begin nBad++; $display("[TB] FAIL stall.hold_insert cyc %0d got %0b want 1", c, insertO); end
        if (dataO !== held) begin nBad++; $display("[TB] FAIL stall.hold_data cyc %0d got %h want %h", c, dataO, held); end
      end
      @(posedge clk);
      modelStep();
    end
  endtask

  task automatic test_type_and();
    resetDut();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 1'b1, 3'h7, 4'b1000, 3'd1, 1'b0, 32'h0, 1'b1, 1'b1);
      #1;
      if (c == 4) begin
        nCmp += 2;
        if (insertO !== 1'b1) begin nBad++; $display("[TB] FAIL and.insert got %0b want 1", insertO); end
        if (dataO !== 32'h0000_7033) begin nBad++; $display("[TB] FAIL and.data got %h want 00007033", dataO); end
      end
      @(posedge clk);
      modelStep();
    end
  endtask

  task automatic test_seed();
    logic expIns;
    resetDut();
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b0, 1'b1, 3'h7, 4'hF, 3'd1, c == 4, 32'h0000_0003, 1'b1, 1'b1);
      #1;
      expIns = mBurst && enI && !rstI;
      nCmp += 2;
      if (insertO !== expIns) begin nBad++; $display("[TB] FAIL seed.insert cyc %0d got %0b want %0b", c, insertO, expIns); end
      if (countO !== mCount[15:0]) begin nBad++; $display("[TB] FAIL seed.count cyc %0d got %0d want %0d", c, countO, mCount); end
      if (c == 8 || c == 9) begin
        nCmp++;
        if (insertO !== (c == 9)) begin nBad++; $display("[TB] FAIL seed.reload cyc %0d got %0b want %0b", c, insertO, c == 9); end
      end
      if (c == 9) begin
        nCmp++;
        if (dataO !== 32'h0000_0033) begin nBad++; $display("[TB] FAIL seed.data got %h want 00000033", dataO); end
      end
      @(posedge clk);
      modelStep();
    end
  endtask

  task automatic test_en_drop();
    resetDut();
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b0, c != 5, 3'h7, 4'hF, 3'd4, 1'b0, 32'h0, 1'b1, 1'b1);
      #1;
      if (c >= 5) begin
        nCmp += 3;
        if (insertO !== 1'b0) begin nBad++; $display("[TB] FAIL endrop.insert cyc %0d got %0b want 0", c, insertO); end
        if (dataO !== 32'h0) begin nBad++; $display("[TB] FAIL endrop.data cyc %0d got %h want 00000000", c, dataO); end
        if (countO !== 16'd1) begin nBad++; $display("[TB] FAIL endrop.count cyc %0d got %0d want 1", c, countO); end
      end
      @(posedge clk);
      modelStep();
    end
  endtask

  task automatic test_reset_mid_burst();
    resetDut();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c == 5, 1'b1, 3'h7, 4'hF, 3'd4, 1'b0, 32'h0, 1'b1, 1'b1);
      #1;
      if (c >= 5 && c <= 6) begin
        nCmp += 2;
        if (insertO !== 1'b0) begin nBad++; $display("[TB] FAIL rstmid.insert cyc %0d got %0b want 0", c, insertO); end
        if (countO !== 16'(c == 5 ? 1 : 0)) begin nBad++; $display("[TB] FAIL rstmid.count cyc %0d got %0d want %0d", c, countO, c == 5 ? 1 : 0); end
      end
      @(posedge clk);
      modelStep();
    end
  endtask

  task automatic test_random();
    logic expIns;
    logic [31:0] expData, seed;
    resetDut();
    for (int c = 0; c < 800; c++) begin
      seed = ($urandom_range(3) == 0) ? mLfsr : $urandom;
      applyStimulus($urandom_range(63) == 0, $urandom_range(7) != 0, 3'($urandom), 4'($urandom),
                    3'($urandom), $urandom_range(15) == 0, seed,
                    $urandom_range(3) != 0, $urandom_range(3) != 0);
      #1;
      expIns  = mBurst && enI && !rstI;
      expData = expIns ? refEncoding(mLfsr, typeEnI) : 32'h0;
      nCmp += 3;
      if (insertO !== expIns) begin nBad++; $display("[TB] FAIL rand.insert cyc %0d got %0b want %0b", c, insertO, expIns); end
      if (dataO !== expData) begin nBad++; $display("[TB] FAIL rand.data cyc %0d got %h want %h", c, dataO, expData); end
      if (countO !== mCount[15:0]) begin nBad++; $display("[TB] FAIL rand.count cyc %0d got %0d want %0d", c, countO, mCount); end
      @(posedge clk);
      modelStep();
    end
  endtask

  initial begin
    test_reset();
    test_default_threshold();
    test_burst3();
    test_stall();
    test_type_and();
    test_seed();
    test_en_drop();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/ibex_dummy_instr_gen.md
IBEX_DUMMY_INSTR_GEN -- requirements
Module: ibex_dummy_instr_gen

Interface
REQ-001 SHALL have parameter CntW, default 5: timeout counter width, 3..8.
REQ-002 SHALL have parameter MaskW, default 3: threshold mask width, 1..CntW.
REQ-003 SHALL have parameter MaxBurst, default 4: max dummies per insertion event, 1..8; BurstW = $clog2(MaxBurst)+1.
REQ-004 SHALL have parameter LfsrSeed, default 32'h0000_0003: LFSR reset value, nonzero.
REQ-005 SHALL have parameter LfsrPoly, default 32'h8020_0003: Galois feedback mask.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 clk_i  in  1  clock, all state on rising edge.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 dummy_instr_en_i  in  1  global enable.
REQ-010 dummy_instr_mask_i  in  MaskW  upper threshold mask bits.
REQ-011 dummy_type_en_i  in  4  per-type enable {AND,DIV,MUL,ADD}.
REQ-012 dummy_burst_len_i  in  BurstW  dummies per event.
REQ-013 dummy_instr_seed_en_i  in  1  seed write strobe.
REQ-014 dummy_instr_seed_i  in  32  seed value.
REQ-015 fetch_valid_i  in  1  real instruction available.
REQ-016 id_in_ready_i  in  1  ID stage accepts.
REQ-017 insert_dummy_instr_o  out  1  dummy presented.
REQ-018 dummy_instr_data_o  out  32  dummy encoding.
REQ-019 dummy_count_o  out  16  accepted-dummy count, saturating.

Function
REQ-020 LFSR SHALL be 32-bit Galois, advance: s <= (s>>1) ^ (s[0] ? LfsrPoly : 0).
REQ-021 LFSR fields SHALL be: cnt = s[CntW-1:0]; op_a = s[CntW+4:CntW]; op_b = s[CntW+9:CntW+5]; type = s[CntW+11:CntW+10].
REQ-022 Seed strobe SHALL load s ^ seed_i (32'h0 result replaced by LfsrSeed); it takes priority over an advance in the same cycle.
REQ-023 Threshold SHALL be cnt & {mask_i, {(CntW-MaskW){1'b1}}}.
REQ-024 FSM states SHALL be IDLE and BURST.
REQ-025 IDLE: cnt_q SHALL increment by 1, modulo 2^CntW, when en & id_in_ready_i & fetch_valid_i.
REQ-026 IDLE: when en and cnt_q == threshold, next state SHALL be BURST, cnt_q cleared to 0, and burst_rem loaded with burst_len_i clamped to [1, MaxBurst] (0 treated as 1).
REQ-027 insert_dummy_instr_o SHALL equal (state==BURST) & dummy_instr_en_i; one cycle latency from threshold match.
REQ-028 Accept SHALL be insert_dummy_instr_o & id_in_ready_i; each accept advances the LFSR, decrements burst_rem and increments dummy_count_o (saturates at 16'hFFFF).
REQ-029 BURST SHALL return to IDLE on an accept with burst_rem==1, or in any cycle with en low.
REQ-030 Type SHALL be the first enabled type scanning type, type+1, ... modulo 4; ADD is used when dummy_type_en_i==0.
REQ-031 Encoding SHALL be {funct7, op_b, op_a, funct3, 5'h00, 7'h33}; ADD 0000000/000, MUL 0000001/000, DIV 0000001/100, AND 0000000/111.
REQ-032 dummy_instr_data_o SHALL be the encoding while insert_dummy_instr_o is high, else 32'h0.
REQ-033 A mask change making threshold < cnt_q SHALL NOT stall: the counter wraps and matches on the next pass.
REQ-034 Output SHALL be held stable while insert is high and id_in_ready_i is low.

Reset
REQ-035 On rst_i, state=IDLE, cnt_q=0, burst_rem=0, LFSR=LfsrSeed, dummy_count_o=0, seed register=0.
REQ-036 During and after reset, insert_dummy_instr_o=0 and dummy_instr_data_o=32'h0.
REQ-037 rst_i mid-BURST SHALL abort the burst in the next cycle with no further accepts counted.

Verification
REQ-038 Defaults, mask=3'b111, type_en=4'hF, burst_len=1, en=fetch_valid=ready=1 -> insert high the cycle after cnt_q==3, data=32'h0000_0033; next threshold 2 (LFSR=32'h8020_0002).
REQ-039 Same setup, burst_len=3 -> three consecutive insert cycles, dummy_count_o=3, then IDLE.
REQ-040 burst_len=2, ready low 4 cycles mid-burst -> insert and data held stable, no LFSR advance.
REQ-041 type_en=4'b1000, LFSR type=0 -> funct7=0000000, funct3=111 (AND).
REQ-042 Seed strobe with seed_i=32'h0000_0003 on LFSR=32'h0000_0003 -> LFSR reloads 32'h0000_0003; concurrent accept does not advance.
REQ-043 en dropped mid-burst -> insert low the same cycle, state IDLE next cycle, count unchanged.
